snake_engine: RTL and testbench

Game-logic core of the Snake datapath. On each game tick it advances the snake one grid cell in the current direction and checks for wall, self and food hits. It keeps the body in a ring buffer and emits a pixel stream (`x_out`, `y_out`, `colour`, `plot`) that erases the old tail and draws the new head. It sits between the direction decoder and rate divider (upstream) and the VGA adapter (downstream).

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/snake_engine_cell_plotter.sv | 53 +++++
 rtl/snake_engine.sv | 209 ++++++++++++++++++++
 tb/tb_snake_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared codes and constants for the snake game-logic core: directions,
// status, colours, FSM states and the reset body placement.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WALL = 2'b01,
    ST_SELF = 2'b10,
    ST_WIN  = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MOVE,
    S_SCAN,
    S_ERASE,
    S_DRAW,
    S_DEAD,
    S_WIN
  } state_e;

  localparam logic [2:0] COL_ERASE = 3'b000;
  localparam logic [2:0] COL_BODY  = 3'b010;

  // Reset body lies on one row, tail at RST_TAIL_X, head at RST_TAIL_X+RST_LEN-1.
  localparam int         RST_LEN    = 3;
  localparam logic [5:0] RST_TAIL_X = 6'd18;
  localparam logic [4:0] RST_Y      = 5'd15;

  // Up/down share bit 1 = 0, left/right share bit 1 = 1; a reversal stays
  // on the same axis but flips bit 0.
  function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] req);
    return (cur[1] == req[1]) && (cur[0] != req[0]);
  endfunction

endpackage

// File: rtl/snake_engine_cell_plotter.sv
// Streams the 16 pixels of one 4x4 grid cell, row-major with x offset
// fastest, starting the cycle after start; done marks the final pixel.
module cell_plotter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] cell_x,
  input  logic [4:0] cell_y,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  logic       active;
  logic [3:0] cnt;
  logic [5:0] cx;
  logic [4:0] cy;
  logic [2:0] col;

  // A start while active restarts the counter, so cells can run back to back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'hF) active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cx  <= cell_x;
      cy  <= cell_y;
      col <= colour_in;
    end
  end

  assign plot   = active;
  assign done   = active && (cnt == 4'hF);
  assign x_out  = active ? {cx, cnt[1:0]} : 8'd0;
  assign y_out  = active ? {cy, cnt[3:2]} : 7'd0;
  assign colour = active ? col : COL_ERASE;

endmodule

// File: rtl/snake_engine.sv
// Snake game-logic core: moves the body one cell per game tick, detects wall,
// self and food hits, and streams erase/draw pixels for the changed cells.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_tick,
  input  logic [1:0] dir,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       ate,
  output logic [1:0] status,
  output logic       busy
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic signed [7:0] GW_S = 8'(GRID_W);
  localparam logic signed [7:0] GH_S = 8'(GRID_H);

  state_e             state, state_nx;
  dir_e               cur_dir;
  logic [5:0]         body_x [MAX_LEN];
  logic [4:0]         body_y [MAX_LEN];
  logic [PTR_W-1:0]   head_ptr, tail_ptr;
  logic [LEN_W-1:0]   len, scan_cnt;
  logic [1:0]         init_seg;
  logic               grow, win_pend;
  logic [5:0]         new_x;
  logic [4:0]         new_y;

  logic signed [7:0]  nx_s, ny_s;
  logic               off_grid, grow_c, hit, scan_last;
  logic [PTR_W-1:0]   scan_idx;
  logic               plt_start, plt_done;
  logic [5:0]         plt_x;
  logic [4:0]         plt_y;
  logic [2:0]         plt_col;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == MAX_LEN - 1) ? '0 : p + 1'b1;
  endfunction

  // Operands are both below MAX_LEN, so a single conditional subtract wraps.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [LEN_W-1:0] off);
    logic [LEN_W:0] s;
    s = (LEN_W+1)'(p) + (LEN_W+1)'(off);
    if (s >= (LEN_W+1)'(MAX_LEN)) s = s - (LEN_W+1)'(MAX_LEN);
    return s[PTR_W-1:0];
  endfunction

  // Candidate head; widened and signed so stepping off either edge is visible.
  always_comb begin
    nx_s = {2'b00, body_x[head_ptr]};
    ny_s = {3'b000, body_y[head_ptr]};
    case (cur_dir)
      DIR_UP:    ny_s = ny_s - 8'sd1;
      DIR_DOWN:  ny_s = ny_s + 8'sd1;
      DIR_LEFT:  nx_s = nx_s - 8'sd1;
      DIR_RIGHT: nx_s = nx_s + 8'sd1;
      default: ;
    endcase
  end

  assign off_grid  = (nx_s < 8'sd0) || (nx_s >= GW_S) || (ny_s < 8'sd0) || (ny_s >= GH_S);
  assign grow_c    = (nx_s[5:0] == food_x) && (ny_s[4:0] == food_y);
  assign scan_idx  = ptr_add(tail_ptr, scan_cnt);
  assign hit       = (body_x[scan_idx] == new_x) && (body_y[scan_idx] == new_y);
  assign scan_last = (scan_cnt == len - 1'b1);

  // Next state and plotter requests; a cell is launched one cycle before the
  // state that owns its pixels so plot lines up with INIT/ERASE/DRAW.
  always_comb begin
    state_nx  = state;
    plt_start = 1'b0;
    plt_x     = new_x;
    plt_y     = new_y;
    plt_col   = COL_BODY;
    case (state)
      S_INIT: begin
        if (!plot) begin
          plt_start = 1'b1;
          plt_x     = body_x[PTR_W'(init_seg)];
          plt_y     = body_y[PTR_W'(init_seg)];
        end else if (plt_done) begin
          if (init_seg == 2'(RST_LEN - 1)) begin
            state_nx = S_IDLE;
          end else begin
            plt_start = 1'b1;
            plt_x     = body_x[PTR_W'(init_seg + 2'd1)];
            plt_y     = body_y[PTR_W'(init_seg + 2'd1)];
          end
        end
      end
      S_IDLE: if (game_tick) state_nx = S_MOVE;
      S_MOVE: state_nx = off_grid ? S_DEAD : S_SCAN;
      S_SCAN: begin
        if (hit) begin
          state_nx = S_DEAD;
        end else if (scan_last) begin
          plt_start = 1'b1;
          if (grow) begin
            state_nx = S_DRAW;
          end else begin
            state_nx = S_ERASE;
            plt_x    = body_x[tail_ptr];
            plt_y    = body_y[tail_ptr];
            plt_col  = COL_ERASE;
          end
        end
      end
      S_ERASE: begin
        if (plt_done) begin
          state_nx  = S_DRAW;
          plt_start = 1'b1;
        end
      end
      S_DRAW: if (plt_done) state_nx = win_pend ? S_WIN : S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_INIT;
      cur_dir  <= DIR_RIGHT;
      head_ptr <= PTR_W'(RST_LEN - 1);
      tail_ptr <= '0;
      len      <= LEN_W'(RST_LEN);
      scan_cnt <= '0;
      init_seg <= '0;
      grow     <= 1'b0;
      win_pend <= 1'b0;
      status   <= ST_RUN;
      ate      <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= (i < RST_LEN) ? RST_TAIL_X + 6'(i) : 6'd0;
        body_y[i] <= RST_Y;
      end
    end else begin
      state <= state_nx;
      busy  <= !(state_nx == S_IDLE || state_nx == S_DEAD);
      ate   <= (state == S_SCAN) && (state_nx == S_DRAW);
      case (state)
        S_INIT: if (plt_done) init_seg <= init_seg + 2'd1;
        S_IDLE: if (game_tick && !is_reversal(cur_dir, dir)) cur_dir <= dir_e'(dir);
        S_MOVE: begin
          grow     <= grow_c;
          scan_cnt <= grow_c ? LEN_W'(0) : LEN_W'(1);
          if (off_grid) status <= ST_WALL;
        end
        S_SCAN: begin
          if (hit) begin
            status <= ST_SELF;
          end else if (scan_last) begin
            // Commit the move: new head enters the ring; the old tail is
            // already latched by the plotter when it is being erased.
            head_ptr <= ptr_inc(head_ptr);
            body_x[ptr_inc(head_ptr)] <= new_x;
            body_y[ptr_inc(head_ptr)] <= new_y;
            win_pend <= grow && (len == LEN_W'(MAX_LEN));
            if (grow) begin
              if (len != LEN_W'(MAX_LEN)) len <= len + 1'b1;
            end else begin
              tail_ptr <= ptr_inc(tail_ptr);
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        S_DRAW: if (plt_done && win_pend) status <= ST_WIN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_MOVE) begin
      new_x <= nx_s[5:0];
      new_y <= ny_s[4:0];
    end
  end

  cell_plotter u_plotter (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (plt_start),
    .cell_x    (plt_x),
    .cell_y    (plt_y),
    .colour_in (plt_col),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .plot      (plot),
    .done      (plt_done)
  );

endmodule

// File: tb/tb_snake_engine.sv
// Randomised and directed bench for snake_engine against a cell-queue model.
module tb_snake_engine;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       game_tick = 1'b0;
  logic [1:0] dir = 2'b11;
  logic [5:0] food_x = '0;
  logic [4:0] food_y = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, ate, busy;
  logic [1:0] status;

  snake_engine #(.GRID_W(40), .GRID_H(30), .MAX_LEN(64)) dut (
    .clk(clk), .reset_n(reset_n), .game_tick(game_tick), .dir(dir),
    .food_x(food_x), .food_y(food_y), .x_out(x_out), .y_out(y_out),
    .colour(colour), .plot(plot), .ate(ate), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Model: body as a cell queue, tail at the front.
  int mx[$];
  int my[$];
  int m_dir;
  int m_status;
  logic [17:0] exp_px[$];
  logic [17:0] got_px[$];
  int ate_cnt;

  always @(negedge clk) begin
    if (plot) got_px.push_back({x_out, y_out, colour});
    if (ate) ate_cnt++;
  end

  function automatic void push_cell(input int cx, input int cy, input logic [2:0] col);
    for (int o = 0; o < 16; o++)
      exp_px.push_back({8'(cx * 4 + o % 4), 7'(cy * 4 + o / 4), col});
  endfunction

  function automatic int eff_dir(input int req);
    return ((req / 2 == m_dir / 2) && (req != m_dir)) ? m_dir : req;
  endfunction

  function automatic void peek(input int req, output int nx, output int ny);
    int d;
    d  = eff_dir(req);
    nx = mx[$] + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
    ny = my[$] + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
  endfunction

  function automatic int model_step(input int req, input int fx, input int fy);
    int nx, ny, first;
    bit grow, hit, full;
    if (m_status != 0) return 0;
    peek(req, nx, ny);
    m_dir = eff_dir(req);
    if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin
      m_status = 1;
      return 0;
    end
    grow  = (nx == fx) && (ny == fy);
    first = grow ? 0 : 1;
    hit   = 0;
    for (int i = first; i < mx.size(); i++)
      if (mx[i] == nx && my[i] == ny) hit = 1;
    if (hit) begin
      m_status = 2;
      return 0;
    end
    full = (mx.size() == 64);
    if (!grow) begin
      push_cell(mx[0], my[0], 3'b000);
      void'(mx.pop_front());
      void'(my.pop_front());
    end
    push_cell(nx, ny, 3'b010);
    mx.push_back(nx);
    my.push_back(ny);
    if (grow && full) m_status = 3;
    return grow ? 1 : 0;
  endfunction

  task automatic compare_px(input string tag);
    int mism;
    mism = 0;
    chk({tag, "_npx"}, got_px.size(), exp_px.size());
    for (int i = 0; i < got_px.size() && i < exp_px.size(); i++)
      if (got_px[i] !== exp_px[i]) mism++;
    chk({tag, "_pxdata"}, mism, 0);
  endtask

  task automatic do_reset(input string tag);
    int cyc;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk({tag, "_zero"}, {x_out, y_out, colour, plot, ate, status, busy}, 0);
    mx = {18, 19, 20};
    my = {15, 15, 15};
    m_dir = 3;
    m_status = 0;
    exp_px.delete();
    for (int i = 0; i < 3; i++) push_cell(mx[i], my[i], 3'b010);
    got_px.delete();
    ate_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_init_done"}, cyc < 200, 1);
    repeat (2) @(negedge clk);
    compare_px({tag, "_init"});
    chk({tag, "_status"}, status, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_tick(input int req, input int fx, input int fy, input bit extra,
                         input string tag);
    int exp_ate, cyc;
    got_px.delete();
    exp_px.delete();
    ate_cnt = 0;
    @(negedge clk);
    food_x = 6'(fx);
    food_y = 5'(fy);
    dir = 2'(req);
    game_tick = 1'b1;
    exp_ate = model_step(req, fx, fy);
    @(negedge clk);
    game_tick = 1'b0;
    if (extra) begin
      repeat (3) @(negedge clk);
      dir = 2'($urandom_range(0, 3));
      game_tick = 1'b1;
      @(negedge clk);
      game_tick = 1'b0;
    end
    repeat (2) @(negedge clk);
    cyc = 0;
    while (busy && status != 2'b11 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, cyc < 300, 1);
    repeat (2) @(negedge clk);
    compare_px(tag);
    chk({tag, "_status"}, status, m_status);
    chk({tag, "_ate"}, ate_cnt, exp_ate);
  endtask

  initial begin
    int nx, ny, req, cyc;
    do_reset("rst");
    do_tick(3, 0, 0, 0, "right");
    do_tick(2, 0, 0, 0, "reverse");
    do_tick(3, 23, 15, 0, "grow4");
    do_tick(3, 24, 15, 0, "grow5");
    do_tick(0, 0, 0, 0, "up");
    do_tick(2, 0, 0, 0, "left");
    do_tick(1, 0, 0, 0, "down_self");
    chk("self_status", status, 2);
    do_tick(3, 0, 0, 0, "self_ignored");

    do_reset("rst_wall");
    for (int k = 0; k < 17; k++) do_tick(0, 0, 0, 0, "wall_up");
    chk("wall_status", status, 1);

    do_reset("rst_win");
    for (int k = 0; k < 62; k++) begin
      req = (k < 19) ? 3 : (k == 19) ? 0 : (k < 58) ? 2 : (k == 58) ? 0 : 3;
      peek(req, nx, ny);
      do_tick(req, nx, ny, 0, "win_path");
    end
    chk("win_status", status, 3);
    chk("win_busy", busy, 1);

    for (int r = 0; r < 3; r++) begin
      do_reset("rst_rand");
      req = 3;
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 1) == 0) req = $urandom_range(0, 3);
        peek(req, nx, ny);
        if ($urandom_range(0, 2) != 0) begin
          nx = $urandom_range(0, 39);
          ny = $urandom_range(0, 29);
        end
        do_tick(req, nx, ny, $urandom_range(0, 3) == 0, "rand");
      end
    end

    do_reset("rst_mid");
    @(negedge clk);
    dir = 2'b11;
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    cyc = 0;
    while (!(plot && colour == 3'b010) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_draw_seen", cyc < 200, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_plot_drop", plot, 0);
    do_reset("replay");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
